// File: rtl/wb_arbiter_pkg.sv
// Shared widths, levels and buffer sizing for the write-back arbiter.
package wb_arbiter_pkg;

  localparam int unsigned RegAddrW   = 5;
  localparam int unsigned RegDataW   = 32;
  localparam int unsigned WbBufDepth = 2;

  localparam logic                RstActive = 1'b0;
  localparam logic                Valid     = 1'b1;
  localparam logic                Enable    = 1'b1;
  localparam logic [RegDataW-1:0] ZeroWord  = '0;

endpackage

// File: rtl/wb_fifo.sv
// Holding FIFO for divider results: per-entry valid bit, cleared by pop or by an
// associative address match from a younger pipeline write.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = WbBufDepth,
  parameter int unsigned ADDR_W = RegAddrW,
  parameter int unsigned DATA_W = RegDataW,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty,
  output logic              any_valid
);

  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clr_en && addr_q[i] == clr_addr) valid_q[i] <= 1'b0;
      end
      if (pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      // Push slot is never the popped slot: push needs !full, pop needs !empty.
      if (push) begin
        addr_q[wr_ptr_q]  <= push_addr;
        data_q[wr_ptr_q]  <= push_data;
        valid_q[wr_ptr_q] <= push_valid;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_valid = valid_q[rd_ptr_q];
  assign head_addr  = addr_q[rd_ptr_q];
  assign head_data  = data_q[rd_ptr_q];
  assign count      = count_q;
  assign full       = (count_q == FullCount);
  assign empty      = (count_q == '0);
  assign any_valid  = |valid_q;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline results win the register-file port, divider
// results drain from a holding buffer into free slots.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH  = WbBufDepth,
  parameter int unsigned ADDR_W = RegAddrW,
  parameter int unsigned DATA_W = RegDataW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              div_valid,
  output logic              div_ready,
  input  logic [ADDR_W-1:0] div_waddr,
  input  logic [DATA_W-1:0] div_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              stall_req,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              pipe_acc, push, push_valid, pop;
  logic              head_valid, full, empty, any_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CntW-1:0]   count;

  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  assign pipe_acc   = (pipe_we == Enable) && (pipe_waddr != '0);
  assign div_ready  = ~full;
  assign push       = div_valid & div_ready;
  // A same-cycle pipeline write to the same register makes the divider result stale.
  assign push_valid = (div_waddr != '0) && !(pipe_acc && pipe_waddr == div_waddr);
  assign pop        = !pipe_acc && !empty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_valid(push_valid),
    .push_addr (div_waddr),
    .push_data (div_wdata),
    .pop       (pop),
    .clr_en    (pipe_acc),
    .clr_addr  (pipe_waddr),
    .head_valid(head_valid),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstActive) begin
      we_q    <= ~Valid;
      waddr_q <= '0;
      wdata_q <= ZeroWord[DATA_W-1:0];
    end else if (pipe_acc) begin
      we_q    <= Valid;
      waddr_q <= pipe_waddr;
      wdata_q <= pipe_wdata;
    end else if (pop) begin
      we_q    <= head_valid;
      waddr_q <= head_addr;
      wdata_q <= head_data;
    end else begin
      we_q    <= ~Valid;
    end
  end

  assign we        = we_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign stall_req = full;
  assign busy      = any_valid;

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=2): pipeline writes, divider drain,
// priority/stall, kill and reset behaviour.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_waddr = '0;
  logic [31:0] pipe_wdata = '0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic [4:0]  div_waddr = '0;
  logic [31:0] div_wdata = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_req;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DEPTH (2),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pipe_we   (pipe_we),
    .pipe_waddr(pipe_waddr),
    .pipe_wdata(pipe_wdata),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_waddr (div_waddr),
    .div_wdata (div_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stall_req (stall_req),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_we    = en;
    pipe_waddr = a;
    pipe_wdata = d;
  endtask

  task automatic div(input logic v, input logic [4:0] a, input logic [31:0] d);
    div_valid = v;
    div_waddr = a;
    div_wdata = d;
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_div_ready", 64'(div_ready), 64'd1);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b1;
    step();

    // Pipeline only
    pipe(1'b1, 5'd3, 32'h1234_5678);
    step();
    check("pipe_we", 64'(we), 64'd1);
    check("pipe_waddr", 64'(waddr), 64'd3);
    check("pipe_wdata", 64'(wdata), 64'h1234_5678);
    pipe(1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    check("pipe_x0_we", 64'(we), 64'd0);
    check("pipe_x0_hold_addr", 64'(waddr), 64'd3);
    check("pipe_x0_hold_data", 64'(wdata), 64'h1234_5678);
    pipe(1'b0, 5'd0, 32'h0);

    // Divider drain: accepted at N, written at N+2
    div(1'b1, 5'd7, 32'hDEAD_BEEF);
    step();
    check("div_n1_we", 64'(we), 64'd0);
    check("div_n1_busy", 64'(busy), 64'd1);
    check("div_n1_ready", 64'(div_ready), 64'd1);
    div(1'b0, 5'd0, 32'h0);
    step();
    check("div_n2_we", 64'(we), 64'd1);
    check("div_n2_waddr", 64'(waddr), 64'd7);
    check("div_n2_wdata", 64'(wdata), 64'hDEAD_BEEF);
    check("div_n2_busy", 64'(busy), 64'd0);
    step();
    check("div_n3_we", 64'(we), 64'd0);

    // Priority and stall
    pipe(1'b1, 5'd1, 32'h100);
    div(1'b1, 5'd4, 32'h44);
    step();
    check("pri_a_waddr", 64'(waddr), 64'd1);
    check("pri_a_ready", 64'(div_ready), 64'd1);
    check("pri_a_stall", 64'(stall_req), 64'd0);
    pipe(1'b1, 5'd1, 32'h101);
    div(1'b1, 5'd5, 32'h55);
    step();
    check("pri_b_wdata", 64'(wdata), 64'h101);
    check("pri_b_ready", 64'(div_ready), 64'd0);
    check("pri_b_stall", 64'(stall_req), 64'd1);
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd1, 32'h102);
    step();
    check("pri_c_waddr", 64'(waddr), 64'd1);
    check("pri_c_wdata", 64'(wdata), 64'h102);
    check("pri_c_stall", 64'(stall_req), 64'd1);
    pipe(1'b0, 5'd0, 32'h0);
    step();
    check("pri_d_we", 64'(we), 64'd1);
    check("pri_d_waddr", 64'(waddr), 64'd4);
    check("pri_d_wdata", 64'(wdata), 64'h44);
    check("pri_d_stall", 64'(stall_req), 64'd0);
    step();
    check("pri_e_we", 64'(we), 64'd1);
    check("pri_e_waddr", 64'(waddr), 64'd5);
    check("pri_e_wdata", 64'(wdata), 64'h55);
    check("pri_e_busy", 64'(busy), 64'd0);
    step();
    check("pri_f_we", 64'(we), 64'd0);

    // Kill: buffered addr 9 overtaken by pipeline write to addr 9
    div(1'b1, 5'd9, 32'h1);
    step();
    check("kill_a_busy", 64'(busy), 64'd1);
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b1, 5'd9, 32'h2);
    step();
    check("kill_b_we", 64'(we), 64'd1);
    check("kill_b_waddr", 64'(waddr), 64'd9);
    check("kill_b_wdata", 64'(wdata), 64'h2);
    check("kill_b_busy", 64'(busy), 64'd0);
    pipe(1'b0, 5'd0, 32'h0);
    step();
    check("kill_c_we", 64'(we), 64'd0);
    check("kill_c_ready", 64'(div_ready), 64'd1);

    // Same-cycle collision on addr 6
    div(1'b1, 5'd6, 32'h66);
    pipe(1'b1, 5'd6, 32'h77);
    step();
    check("col_a_we", 64'(we), 64'd1);
    check("col_a_waddr", 64'(waddr), 64'd6);
    check("col_a_wdata", 64'(wdata), 64'h77);
    check("col_a_busy", 64'(busy), 64'd0);
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    step();
    check("col_b_we", 64'(we), 64'd0);
    check("col_b_ready", 64'(div_ready), 64'd1);

    // Reset mid-operation with one buffered entry
    div(1'b1, 5'd10, 32'hA);
    pipe(1'b1, 5'd11, 32'hB);
    step();
    check("mrst_pre_we", 64'(we), 64'd1);
    check("mrst_pre_busy", 64'(busy), 64'd1);
    div(1'b0, 5'd0, 32'h0);
    pipe(1'b0, 5'd0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_we", 64'(we), 64'd0);
    check("mrst_waddr", 64'(waddr), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    step();
    rst = 1'b1;
    step();
    check("post_rst_we", 64'(we), 64'd0);
    check("post_rst_ready", 64'(div_ready), 64'd1);
    check("post_rst_stall", 64'(stall_req), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
